// File: rtl/kbd_scancode_decoder.sv
// rtl/kbd_scancode_decoder.sv - PS/2 Set-2 scan-code stream to held keypad/enter levels
//
// Turns received scan-code bytes into level-held key state. Make codes set the mapped
// bit and break codes clear it. Consumers do their own edge detection on these levels.
//
// Ports:
//   clk            in   1   system clock
//   resetN         in   1   asynchronous active-low reset
//   din            in   8   received scan-code byte
//   din_valid      in   1   one-cycle strobe, din valid
//   din_err        in   1   one-cycle strobe, framing/parity error on current byte
//   key_is_pressed out  10  held state, bit n = keypad digit n (arrows alias to 8/2/4/6)
//   enter          out  1   held state, Enter or keypad Enter
//   make_strobe    out  1   one-cycle pulse on any mapped make (typematic repeats included)
//   seq_state      out  2   decoder state: 0 IDLE, 1 EXT, 2 BRK, 3 PAUSE
//
// Build option: define KBD_PREFIX_TIMEOUT_EN to abandon a prefix sequence after
// TIMEOUT_CYCLES idle cycles. Without it the decoder leaves a non-IDLE state only
// on bytes or din_err.

module kbd_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_err,
    output logic [9:0] key_is_pressed,
    output logic       enter,
    output logic       make_strobe,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXT   = 2'd1,
        S_BRK   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam int PW = $clog2(PAUSE_SKIP + 1);

    state_t        state;
    logic          ext;
    logic [PW-1:0] pause_cnt;

    // Mapping is looked up in whichever code table applies to the current byte:
    // extended while in EXT, or in BRK when the break was prefixed by E0.
    logic       code_ext;
    logic       map_hit;
    logic       map_enter;
    logic [3:0] map_idx;

    assign code_ext = (state == S_EXT) || ((state == S_BRK) && ext);

    always_comb begin
        map_hit   = 1'b0;
        map_enter = 1'b0;
        map_idx   = 4'd0;
        if (!code_ext) begin
            case (din)
                8'h70: begin map_hit = 1'b1; map_idx = 4'd0; end
                8'h69: begin map_hit = 1'b1; map_idx = 4'd1; end
                8'h72: begin map_hit = 1'b1; map_idx = 4'd2; end
                8'h7A: begin map_hit = 1'b1; map_idx = 4'd3; end
                8'h6B: begin map_hit = 1'b1; map_idx = 4'd4; end
                8'h73: begin map_hit = 1'b1; map_idx = 4'd5; end
                8'h74: begin map_hit = 1'b1; map_idx = 4'd6; end
                8'h6C: begin map_hit = 1'b1; map_idx = 4'd7; end
                8'h75: begin map_hit = 1'b1; map_idx = 4'd8; end
                8'h7D: begin map_hit = 1'b1; map_idx = 4'd9; end
                8'h5A: begin map_hit = 1'b1; map_enter = 1'b1; end
                default: ;
            endcase
        end else begin
            // Arrows share bits with keypad 8/2/4/6; E0 12 and friends stay unmapped.
            case (din)
                8'h75: begin map_hit = 1'b1; map_idx = 4'd8; end
                8'h72: begin map_hit = 1'b1; map_idx = 4'd2; end
                8'h6B: begin map_hit = 1'b1; map_idx = 4'd4; end
                8'h74: begin map_hit = 1'b1; map_idx = 4'd6; end
                8'h5A: begin map_hit = 1'b1; map_enter = 1'b1; end
                default: ;
            endcase
        end
    end

`ifdef KBD_PREFIX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    assign to_hit = (state != S_IDLE) && !din_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            to_cnt <= '0;
        end else if (din_valid || (state == S_IDLE) || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic to_hit;
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= S_IDLE;
            ext            <= 1'b0;
            pause_cnt      <= '0;
            key_is_pressed <= '0;
            enter          <= 1'b0;
            make_strobe    <= 1'b0;
        end else begin
            make_strobe <= 1'b0;
            if (din_err) begin
                // Errored byte is dropped and any partial sequence is abandoned.
                state     <= S_IDLE;
                ext       <= 1'b0;
                pause_cnt <= '0;
            end else if (din_valid) begin
                case (state)
                    S_IDLE: begin
                        if (din == 8'hE0) begin
                            state <= S_EXT;
                        end else if (din == 8'hF0) begin
                            state <= S_BRK;
                            ext   <= 1'b0;
                        end else if (din == 8'hE1) begin
                            state     <= S_PAUSE;
                            pause_cnt <= PW'(PAUSE_SKIP);
                        end else if (map_hit) begin
                            if (map_enter) enter <= 1'b1;
                            else           key_is_pressed[map_idx] <= 1'b1;
                            make_strobe <= 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (din == 8'hF0) begin
                            state <= S_BRK;
                            ext   <= 1'b1;
                        end else if ((din != 8'hE0) && (din != 8'hE1)) begin
                            state <= S_IDLE;
                            if (map_hit) begin
                                if (map_enter) enter <= 1'b1;
                                else           key_is_pressed[map_idx] <= 1'b1;
                                make_strobe <= 1'b1;
                            end
                        end
                    end
                    S_BRK: begin
                        state <= S_IDLE;
                        ext   <= 1'b0;
                        if (map_hit) begin
                            if (map_enter) enter <= 1'b0;
                            else           key_is_pressed[map_idx] <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        // Pause/Break has no break code; just swallow its fixed tail.
                        if (pause_cnt <= PW'(1)) begin
                            state     <= S_IDLE;
                            pause_cnt <= '0;
                        end else begin
                            pause_cnt <= pause_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (to_hit) begin
                state     <= S_IDLE;
                ext       <= 1'b0;
                pause_cnt <= '0;
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// tb/tb_kbd_scancode_decoder.sv - scoreboard bench for kbd_scancode_decoder

module tb_kbd_scancode_decoder;

`ifdef KBD_PREFIX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1_500_000;
`endif
    localparam int SKIP = 7;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] din;
    logic       din_valid;
    logic       din_err;
    logic [9:0] key_is_pressed;
    logic       enter;
    logic       make_strobe;
    logic [1:0] seq_state;

    always #5 clk = ~clk;

    kbd_scancode_decoder #(.TIMEOUT_CYCLES(TO), .PAUSE_SKIP(SKIP)) dut (
        .clk(clk), .resetN(resetN), .din(din), .din_valid(din_valid), .din_err(din_err),
        .key_is_pressed(key_is_pressed), .enter(enter), .make_strobe(make_strobe),
        .seq_state(seq_state)
    );

    typedef struct packed {
        logic [9:0] keys;
        logic       ent;
        logic       stb;
        logic [1:0] st;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pending-prefix flags plus a count of pause bytes still to swallow.
    bit         m_e0, m_f0;
    int         m_pause;
    logic [9:0] m_keys;
    logic       m_ent;
    logic [9:0] last_keys;
    logic       last_ent;
`ifdef KBD_PREFIX_TIMEOUT_EN
    int         m_gap;
`endif

    logic [7:0] norm_tab [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] ext_code [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
    int         ext_dig  [4]  = '{8, 2, 4, 6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (m_pause > 0) return 2'd3;
        if (m_f0)        return 2'd2;
        if (m_e0)        return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_clear_seq();
        m_e0 = 0; m_f0 = 0; m_pause = 0;
    endtask

    task automatic apply_key(input bit is_ext, input bit is_brk, input logic [7:0] b, output logic stb);
        int dig;
        dig = -1;
        stb = 1'b0;
        if (b == 8'h5A) dig = 10;
        else if (!is_ext) begin
            for (int i = 0; i < 10; i++) if (norm_tab[i] == b) dig = i;
        end else begin
            for (int i = 0; i < 4; i++) if (ext_code[i] == b) dig = ext_dig[i];
        end
        if (dig == 10)     m_ent = !is_brk;
        else if (dig >= 0) m_keys[dig] = !is_brk;
        stb = (dig >= 0) && !is_brk;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic stb);
        stb = 1'b0;
        if (m_pause > 0)                           m_pause--;
        else if (!m_e0 && !m_f0 && b == 8'hE1)     m_pause = SKIP;
        else if (!m_f0 && b == 8'hE0)              m_e0 = 1;
        else if (!m_f0 && m_e0 && b == 8'hE1)      ;
        else if (!m_f0 && b == 8'hF0)              m_f0 = 1;
        else begin
            apply_key(m_e0, m_f0, b, stb);
            model_clear_seq();
        end
    endtask

    // One clock of stimulus: drive on the falling edge, update the model, queue the expectation.
    task automatic cyc(input bit v, input logic [7:0] b, input bit e);
        logic stb;
        exp_t x;
        @(negedge clk);
        din_valid = v; din = b; din_err = e;
        stb = 1'b0;
        if (e) model_clear_seq();
        else if (v) model_byte(b, stb);
`ifdef KBD_PREFIX_TIMEOUT_EN
        if (v || e) m_gap = 0;
        else begin
            m_gap++;
            if (m_gap == TO) model_clear_seq();
        end
`endif
        if (v) begin
            x.keys = m_keys; x.ent = m_ent; x.stb = stb; x.st = exp_state();
            sbq.push_back(x);
        end
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0; din_valid = 1'b0; din_err = 1'b0;
        #1;
        chk("rst_keys", 32'(key_is_pressed), 0);
        chk("rst_enter", 32'(enter), 0);
        chk("rst_strobe", 32'(make_strobe), 0);
        chk("rst_state", 32'(seq_state), 0);
        model_clear_seq();
        m_keys = '0; m_ent = 1'b0; last_keys = '0; last_ent = 1'b0;
`ifdef KBD_PREFIX_TIMEOUT_EN
        m_gap = 0;
`endif
        sbq.delete();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    // Monitor: every cycle out of reset either pops one expectation (byte consumed) or
    // requires held outputs to stay put with no strobe.
    logic took;
    exp_t cur;
    always @(posedge clk) begin
        took = resetN && din_valid;
        #1;
        if (resetN) begin
            if (took) begin
                if (sbq.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    cur = sbq.pop_front();
                    chk("keys", 32'(key_is_pressed), 32'(cur.keys));
                    chk("enter", 32'(enter), 32'(cur.ent));
                    chk("strobe", 32'(make_strobe), 32'(cur.stb));
                    chk("state", 32'(seq_state), 32'(cur.st));
                    last_keys = cur.keys;
                    last_ent  = cur.ent;
                end
            end else begin
                chk("hold_keys", 32'(key_is_pressed), 32'(last_keys));
                chk("hold_enter", 32'(enter), 32'(last_ent));
                chk("hold_strobe", 32'(make_strobe), 0);
                chk("hold_state", 32'(seq_state), 32'(exp_state()));
            end
        end
    end

    logic [7:0] pool [16] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B,
                              8'h74, 8'h5A, 8'h70, 8'h69, 8'h7A, 8'h73, 8'h12, 8'h7D};
    logic [7:0] rb;
    int         r;

    initial begin
        resetN = 1'b0; din = 8'h00; din_valid = 1'b0; din_err = 1'b0;
        m_keys = '0; m_ent = 1'b0; last_keys = '0; last_ent = 1'b0;
        model_clear_seq();
`ifdef KBD_PREFIX_TIMEOUT_EN
        m_gap = 0;
`endif
        do_reset();
        idle(2);

        send(8'h75); idle(2); send(8'hF0); send(8'h75); idle(1);
        send(8'hE0); send(8'h72); send(8'hE0); send(8'hF0); send(8'h72); idle(1);
        send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A); send(8'hE0); send(8'h5A);
        send(8'h75); send(8'h75); send(8'hE0); send(8'h12); idle(1);
        foreach (pool[i]) if (0) ;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
        send(8'h14); send(8'hF0); send(8'h77); idle(1); send(8'h70);
        send(8'hF0); cyc(1'b0, 8'h00, 1'b1); send(8'h69); idle(1);
        send(8'hF0); cyc(1'b1, 8'h75, 1'b1); send(8'h75);
        send(8'hE0); send(8'hE1); send(8'hE0); send(8'h74);
        send(8'hE0); do_reset(); idle(2);
`ifdef KBD_PREFIX_TIMEOUT_EN
        send(8'hE0); idle(20); send(8'h75); idle(1);
        send(8'hE1); send(8'h14); idle(17); send(8'h6B); idle(1);
`endif

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       idle(1);
            else if (r < 10) cyc(1'b0, 8'h00, 1'b1);
            else if (r < 12) cyc(1'b1, 8'($urandom), 1'b1);
            else if (r < 13) send(8'hE1);
            else if (r < 18) send(8'($urandom));
            else begin
                rb = pool[$urandom_range(0, 15)];
                send(rb);
            end
        end
        idle(3);
        chk("sb_drain", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
